// File: rtl/uart_rx_control.sv
// Receive control for the UART RX path: synchronizes the raw line, detects
// the start bit, gates the bit timer for one packet, checks the stop bit and
// either strobes the data buffer or raises a sticky framing error.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | line idle, waiting for a synchronized falling edge
// S_CLEAR   | one cycle: clear stop-bit checker / shift register
// S_RECEIVE | timer enabled, waiting for packet_done
// S_CHECK   | timer stopped, stop bit evaluated
// S_LOAD    | one cycle: shift register holds a valid byte
// S_ERROR   | one cycle: stop bit was 0, framing error latched
module uart_rx_control #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   input  logic packet_done,
   input  logic stop_bit,
   output logic enable_timer,
   output logic sbc_clear,
   output logic load_buffer,
   output logic framing_error,
   output logic rx_busy,
   output logic start_bit_detected
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RECEIVE = 3'd2,
      S_CHECK   = 3'd3,
      S_LOAD    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_enable_timer;
   logic                   r_sbc_clear;
   logic                   r_load_buffer;
   logic                   r_framing_error;
   logic                   r_rx_busy;
   logic                   w_sync_out;
   logic                   w_start;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_start    = r_prev & ~w_sync_out;

   // Line synchronizer and edge history; reset to the idle (high) level so
   // a line held low through reset release is seen as a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], serial_in};
         r_prev <= w_sync_out;
      end
   end

   // Packet sequencer; outputs are registered from the next state so they
   // match a Moore decode of the state register cycle for cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_enable_timer  <= 1'b0;
         r_sbc_clear     <= 1'b0;
         r_load_buffer   <= 1'b0;
         r_framing_error <= 1'b0;
         r_rx_busy       <= 1'b0;
      end else begin
         r_enable_timer <= 1'b0;
         r_sbc_clear    <= 1'b0;
         r_load_buffer  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state     <= S_CLEAR;
                  r_sbc_clear <= 1'b1;
                  r_rx_busy   <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state         <= S_RECEIVE;
               r_enable_timer  <= 1'b1;
               r_framing_error <= 1'b0;
            end
            S_RECEIVE: begin
               if (packet_done) begin
                  r_state <= S_CHECK;
               end else begin
                  r_enable_timer <= 1'b1;
               end
            end
            S_CHECK: begin
               if (stop_bit) begin
                  r_state       <= S_LOAD;
                  r_load_buffer <= 1'b1;
               end else begin
                  r_state         <= S_ERROR;
                  r_framing_error <= 1'b1;
               end
            end
            S_LOAD, S_ERROR: begin
               r_state   <= S_IDLE;
               r_rx_busy <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_rx_busy <= 1'b0;
            end
         endcase
      end
   end

   assign enable_timer       = r_enable_timer;
   assign sbc_clear          = r_sbc_clear;
   assign load_buffer        = r_load_buffer;
   assign framing_error      = r_framing_error;
   assign rx_busy            = r_rx_busy;
   assign start_bit_detected = w_start;

endmodule

// File: tb/tb_uart_rx_control.sv
// Bench for uart_rx_control: a timeline model of the packet (cycles since
// CLEAR entry, cycle of packet_done) checked every cycle, plus directed
// packets with literal cycle-count expectations.
module tb_uart_rx_control;

   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic serial_in = 1'b1;
   logic packet_done = 1'b0;
   logic stop_bit = 1'b1;
   logic enable_timer, sbc_clear, load_buffer, framing_error, rx_busy, start_bit_detected;

   int n_checks = 0;
   int n_fail = 0;

   // model: line sample history and packet timeline
   bit h[0:SYNC];
   int pos = -1;
   int done_at = -1;
   bit stop_val = 1'b1;
   bit m_fe = 1'b0;
   bit st_prev;
   bit e_start, e_clr, e_en, e_ld, e_busy;

   int clr_cnt = 0;
   int ld_cnt = 0;
   int st_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_control #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk),
      .rst(rst),
      .serial_in(serial_in),
      .packet_done(packet_done),
      .stop_bit(stop_bit),
      .enable_timer(enable_timer),
      .sbc_clear(sbc_clear),
      .load_buffer(load_buffer),
      .framing_error(framing_error),
      .rx_busy(rx_busy),
      .start_bit_detected(start_bit_detected)
   );

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 60)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 60)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model update at each edge, then compare all outputs just after it
   always @(posedge clk) begin
      if (rst) begin
         pos = -1;
         done_at = -1;
         m_fe = 1'b0;
         stop_val = 1'b1;
         for (int i = 0; i <= SYNC; i++) h[i] = 1'b1;
      end else begin
         st_prev = h[SYNC] & ~h[SYNC-1];
         if (pos < 0) begin
            if (st_prev) begin
               pos = 0;
               done_at = -1;
            end
         end else begin
            if (pos >= 1 && done_at < 0 && packet_done) done_at = pos;
            if (done_at >= 0 && pos == done_at + 1) stop_val = stop_bit;
            if (pos == 0) m_fe = 1'b0;
            pos++;
            if (done_at >= 0 && pos == done_at + 2 && !stop_val) m_fe = 1'b1;
            if (done_at >= 0 && pos > done_at + 2) pos = -1;
         end
         for (int i = SYNC; i > 0; i--) h[i] = h[i-1];
         h[0] = serial_in;
      end
      e_start = h[SYNC] & ~h[SYNC-1];
      e_busy  = (pos >= 0);
      e_clr   = (pos == 0);
      e_en    = (pos >= 1) && (done_at < 0 || pos <= done_at);
      e_ld    = (done_at >= 0) && (pos == done_at + 2) && stop_val;
      #1;
      check("start_bit_detected", start_bit_detected, e_start);
      check("sbc_clear", sbc_clear, e_clr);
      check("enable_timer", enable_timer, e_en);
      check("load_buffer", load_buffer, e_ld);
      check("framing_error", framing_error, m_fe);
      check("rx_busy", rx_busy, e_busy);
      clr_cnt += int'(sbc_clear);
      ld_cnt  += int'(load_buffer);
      st_cnt  += int'(start_bit_detected);
   end

   // Start bit at edge k, packet_done in the 21st RECEIVE cycle.
   task automatic directed_packet(input bit stop, input bit glitch);
      int en_cnt, ld0, clr0;
      @(negedge clk);
      serial_in = 1'b0;
      ld0 = ld_cnt;
      clr0 = clr_cnt;
      @(posedge clk);                    // edge k
      @(posedge clk); #2;                // after k+1
      check("start_after_k1", start_bit_detected, 1'b1);
      @(negedge clk);
      serial_in = 1'b1;
      @(posedge clk); #2;                // after k+2
      check("sbc_clear_after_k2", sbc_clear, 1'b1);
      @(posedge clk); #2;                // after k+3: first RECEIVE cycle
      check("enable_at_receive_entry", enable_timer, 1'b1);
      check("fe_clear_after_clear", framing_error, 1'b0);
      en_cnt = int'(enable_timer);
      for (int i = 2; i <= 21; i++) begin
         if (glitch && i >= 5 && i <= 8) begin
            @(negedge clk);
            serial_in = (i % 2 == 1) ? 1'b0 : 1'b1;
         end
         @(posedge clk); #2;
         en_cnt += int'(enable_timer);
      end
      @(negedge clk);
      packet_done = 1'b1;
      stop_bit = stop;
      @(posedge clk); #2;                // CHECK
      check("enable_low_in_check", enable_timer, 1'b0);
      check("no_load_in_check", load_buffer, 1'b0);
      @(negedge clk);
      packet_done = 1'b0;
      @(posedge clk); #2;                // LOAD or ERROR
      check("load_two_after_done", load_buffer, stop);
      check("fe_after_packet", framing_error, ~stop);
      check("busy_in_last_state", rx_busy, 1'b1);
      @(posedge clk); #2;                // back in IDLE
      check("idle_after_packet", rx_busy, 1'b0);
      check_int("enable_cycles", en_cnt, 21);
      check_int("load_pulses", ld_cnt - ld0, stop ? 1 : 0);
      check_int("clear_pulses", clr_cnt - clr0, 1);
   endtask

   initial begin
      int ld0, st0;
      for (int i = 0; i <= SYNC; i++) h[i] = 1'b1;
      rst = 1'b1;
      serial_in = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("rst_enable", enable_timer, 1'b0);
      check("rst_clear", sbc_clear, 1'b0);
      check("rst_load", load_buffer, 1'b0);
      check("rst_fe", framing_error, 1'b0);
      check("rst_busy", rx_busy, 1'b0);
      check("rst_start", start_bit_detected, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      st0 = st_cnt;
      repeat (10) @(posedge clk);
      #2;
      check_int("idle_no_start", st_cnt - st0, 0);
      check("idle_not_busy", rx_busy, 1'b0);

      // good packet, framing error, recovery, mid-packet edges
      directed_packet(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      directed_packet(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         check("fe_sticky_idle", framing_error, 1'b1);
      end
      directed_packet(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      directed_packet(1'b1, 1'b1);
      repeat (3) @(posedge clk);

      // reset 5 cycles into RECEIVE
      @(negedge clk);
      serial_in = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("mid_rst_receiving", enable_timer, 1'b1);
      @(negedge clk);
      serial_in = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_enable", enable_timer, 1'b0);
      check("mid_rst_clear", sbc_clear, 1'b0);
      check("mid_rst_load", load_buffer, 1'b0);
      check("mid_rst_busy", rx_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      ld0 = ld_cnt;
      repeat (10) @(posedge clk);
      #2;
      check("post_rst_idle", rx_busy, 1'b0);
      check_int("post_rst_no_load", ld_cnt - ld0, 0);

      // line low while reset releases
      @(negedge clk);
      rst = 1'b1;
      serial_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      st0 = st_cnt;
      @(posedge clk);
      @(posedge clk); #2;
      check("low_release_start", start_bit_detected, 1'b1);
      @(posedge clk); #2;
      check("low_release_clear", sbc_clear, 1'b1);
      check_int("low_release_one_pulse", st_cnt - st0, 1);
      @(negedge clk);
      serial_in = 1'b1;
      repeat (3) @(negedge clk);
      packet_done = 1'b1;
      stop_bit = 1'b1;
      @(negedge clk);
      packet_done = 1'b0;
      repeat (6) @(posedge clk);

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         serial_in   = ($urandom_range(0, 5) != 0);
         packet_done = ($urandom_range(0, 11) == 0);
         stop_bit    = ($urandom_range(0, 3) != 0);
         rst         = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      serial_in = 1'b1;
      packet_done = 1'b0;
      repeat (40) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_control.md
Name: uart_rx_control

Overview:
- Receive control unit of the APB UART receiver.
- Sits directly upstream of the bit timer: detects the start bit on the raw serial line and drives enable_timer for the duration of a packet.
- Consumes packet_done from the timer and validates the stop bit sampled by the shift register.
- Issues the buffer-load strobe to the RX data buffer and flags framing errors to the APB status logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the serial_in synchronizer (legal range 2..4).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  raw RX line, asynchronous; idles high.
- packet_done  input  1  one-cycle pulse from timer: last bit (stop bit) sampled.
- stop_bit  input  1  stop-bit value held by the shift register, valid while packet_done is high and after it.
- enable_timer  output  1  high while a packet is being received.
- sbc_clear  output  1  one-cycle clear to the stop-bit checker and shift register at packet start.
- load_buffer  output  1  one-cycle strobe: shift register contents are a valid byte.
- framing_error  output  1  sticky flag: last packet had stop_bit = 0.
- rx_busy  output  1  high in any state other than IDLE.
- start_bit_detected  output  1  one-cycle pulse on a synchronized high-to-low transition (debug/status).

Behaviour:
- Reset (async, rst = 1):
  - FSM goes to IDLE.
  - All synchronizer flops and the edge-history flop set to 1.
  - All outputs are 0.
- Synchronizer: SYNC_STAGES flops in series; sync_out is the last flop.
- Edge detector: prev_q <= sync_out each cycle; start_bit_detected = prev_q & ~sync_out (combinational from flops).
- Start-detect latency (SYNC_STAGES = 2):
  - serial_in low at edge k → sync_out low after edge k+1.
  - start_bit_detected high during the cycle after edge k+1.
  - FSM enters CLEAR at edge k+2 and RECEIVE at edge k+3.
- FSM states and outputs (Moore-decoded from the state register):
  - IDLE: all outputs 0. start_bit_detected → CLEAR.
  - CLEAR: sbc_clear = 1, rx_busy = 1; framing_error cleared at the exit edge. Unconditionally → RECEIVE.
  - RECEIVE: enable_timer = 1, rx_busy = 1. packet_done → CHECK; otherwise stay.
  - CHECK: enable_timer = 0, rx_busy = 1. stop_bit = 1 → LOAD; stop_bit = 0 → ERROR.
  - LOAD: load_buffer = 1, rx_busy = 1. → IDLE.
  - ERROR: framing_error set at the entry edge; rx_busy = 1; load_buffer stays 0. → IDLE.
- framing_error: register, set on entry to ERROR, cleared on exit from CLEAR; holds its value in all other states.
- Boundary conditions:
  - Edges seen outside IDLE are ignored; no restart mid-packet.
  - packet_done outside RECEIVE is ignored.
  - packet_done in the first RECEIVE cycle: legal, goes to CHECK next edge.
  - Start edge in the cycle the FSM returns to IDLE from LOAD/ERROR: the pulse arrives while the FSM is not yet in IDLE and is lost. A start edge one cycle later is taken.
  - serial_in held low when rst deasserts: the synchronizer propagates the 1→0 change, so it is treated as a start bit SYNC_STAGES cycles after release.
  - rst asserted mid-packet: immediate return to IDLE; enable_timer, sbc_clear and load_buffer drop asynchronously; framing_error clears.
  - Single-cycle low glitches shorter than one clock may or may not be detected; no glitch filter is provided.
- Packet cycle count: IDLE→IDLE is 3 (CLEAR, CHECK, LOAD/ERROR) + RECEIVE cycles.

Test Plan:
- Reset: rst = 1, serial_in = 1 → all outputs 0. Release rst, hold line high 10 cycles → no start_bit_detected, state IDLE.
- Good packet:
  - Stimulus: drive serial_in low at negedge (edge k); pulse packet_done 20 cycles after RECEIVE entry with stop_bit = 1.
  - Response: start_bit_detected at cycle k+2; sbc_clear one cycle at k+3; enable_timer high exactly 20 cycles plus the packet_done cycle; load_buffer one cycle, two cycles after packet_done; framing_error = 0.
- Framing error: same as above with stop_bit = 0 → load_buffer never asserts; framing_error = 1 and stays 1 through 5 idle cycles. A following good packet → framing_error clears the edge after sbc_clear.
- Edge during RECEIVE: toggle serial_in 1→0→1 twice mid-packet → no sbc_clear, single load_buffer pulse at end.
- Reset mid-packet: assert rst 5 cycles into RECEIVE → enable_timer = 0 immediately. After release with line high → stays IDLE, no load_buffer.
- Low line at reset release: serial_in = 0 when rst deasserts → start_bit_detected pulses once SYNC_STAGES cycles later, and the FSM enters CLEAR.
